// File: rtl/note_pkg.sv
// Shared types, note frequency table and window-bound helper for note_tracker.
package note_pkg;

    localparam int W_NOTE = 12;

    typedef enum logic [3:0] {
        NOTE_C, NOTE_CS, NOTE_D, NOTE_DS, NOTE_E, NOTE_F,
        NOTE_FS, NOTE_G, NOTE_GS, NOTE_A, NOTE_AS, NOTE_B
    } note_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_DONE
    } search_state_e;

    localparam logic [W_NOTE-1:0] NO_NOTE = '0;

    // Octave-4 frequencies in units of 0.01 Hz, C first.
    localparam int unsigned FREQ_100 [12] = '{
        26163, 27718, 29366, 31113, 32963, 34923,
        36999, 39200, 41530, 44000, 46616, 49388
    };

    // Elaboration-time period bound (clk cycles) for table entry idx = octave*12 + note.
    function automatic logic [63:0] win_bound(input int clk_mhz, input int idx,
                                               input int tol_pct, input logic upper);
        logic [3:0]  n;
        logic [63:0] nominal;
        n       = 4'(idx % 12);
        nominal = (64'(clk_mhz) * 64'd100_000_000) / (64'(FREQ_100[n]) << (idx / 12));
        if (upper) begin
            return (nominal * 64'(100 + tol_pct)) / 64'd100;
        end
        return (nominal * 64'(100 - tol_pct)) / 64'd100;
    endfunction

    function automatic logic [W_NOTE-1:0] note_onehot_f(input logic [3:0] idx);
        return 12'h800 >> idx;
    endfunction

endpackage

// File: rtl/note_period_meter.sv
// Hysteresis zero-crossing detector and free-running period counter with saturation timeout.
module note_period_meter #(
    parameter int W_SAMPLE = 16,
    parameter int W_CNT    = 20
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic signed [W_SAMPLE-1:0] i_sample,
    input  logic                       i_sample_vld,
    input  logic signed [W_SAMPLE-1:0] i_thr_hi,
    input  logic signed [W_SAMPLE-1:0] i_thr_lo,
    output logic [W_CNT-1:0]           o_period,
    output logic                       o_period_vld,
    output logic                       o_timeout
);

    logic             r_high;
    logic             r_first_edge;
    logic [W_CNT-1:0] r_cnt;
    logic [W_CNT-1:0] r_period;
    logic             r_period_vld;
    logic             w_rise;
    logic             w_fall;
    logic             w_sat;
    logic             w_timeout;

    assign w_rise    = i_sample_vld && !r_high && (i_sample >= i_thr_hi);
    assign w_fall    = i_sample_vld && r_high && (i_sample < i_thr_lo);
    assign w_sat     = &r_cnt;
    assign w_timeout = w_sat && !r_first_edge;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_high       <= 1'b0;
            r_first_edge <= 1'b1;
            r_cnt        <= '0;
            r_period     <= '0;
            r_period_vld <= 1'b0;
        end else begin
            r_period_vld <= 1'b0;
            if (w_rise) begin
                r_high <= 1'b1;
            end else if (w_fall) begin
                r_high <= 1'b0;
            end
            // A saturated count is never a valid period; the next edge restarts measurement.
            if (w_timeout) begin
                r_first_edge <= 1'b1;
            end else if (w_rise) begin
                if (r_first_edge) begin
                    r_first_edge <= 1'b0;
                end else begin
                    r_period     <= r_cnt + 1'b1;
                    r_period_vld <= 1'b1;
                end
                r_cnt <= '0;
            end else if (!w_sat) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_period     = r_period;
    assign o_period_vld = r_period_vld;
    assign o_timeout    = w_timeout;

endmodule

// File: rtl/note_tracker.sv
// Period-based note classifier with sequential table search and stability filter.
// Define NOTE_TRACKER_AVG_EN to classify the mean of the last four periods.
module note_tracker
    import note_pkg::*;
#(
    parameter int   CLK_MHZ        = 50,
    parameter int   W_SAMPLE       = 16,
    parameter int   W_CNT          = 20,
    parameter int   N_OCT          = 3,
    parameter int   TOL_PCT        = 3,
    parameter int   STABLE_PERIODS = 4,
    localparam int  W_OCT          = (N_OCT > 1) ? $clog2(N_OCT) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [W_SAMPLE-1:0] sample,
    input  logic                       sample_vld,
    input  logic signed [W_SAMPLE-1:0] thr_hi,
    input  logic signed [W_SAMPLE-1:0] thr_lo,
    output logic [W_CNT-1:0]           period,
    output logic                       period_vld,
    output logic [W_NOTE-1:0]          note_onehot,
    output logic [3:0]                 note_idx,
    output logic [W_OCT-1:0]           octave,
    output logic                       note_vld
);

    localparam int N_ENT = 12 * N_OCT;
    localparam int W_K   = $clog2(N_ENT);
    localparam int W_FC  = $clog2(STABLE_PERIODS + 1);

    logic [W_CNT-1:0] w_period;
    logic             w_period_vld;
    logic             w_timeout;
    logic [W_CNT-1:0] w_feed_period;
    logic             w_feed_ok;

    note_period_meter #(.W_SAMPLE(W_SAMPLE), .W_CNT(W_CNT)) u_meter (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_sample     (sample),
        .i_sample_vld (sample_vld),
        .i_thr_hi     (thr_hi),
        .i_thr_lo     (thr_lo),
        .o_period     (w_period),
        .o_period_vld (w_period_vld),
        .o_timeout    (w_timeout)
    );

    assign period     = w_period;
    assign period_vld = w_period_vld;

`ifdef NOTE_TRACKER_AVG_EN
    logic [W_CNT-1:0] r_hist [3];
    logic [1:0]       r_hist_n;
    logic [W_CNT+1:0] w_sum;

    assign w_sum = (W_CNT+2)'(w_period) + (W_CNT+2)'(r_hist[0])
                 + (W_CNT+2)'(r_hist[1]) + (W_CNT+2)'(r_hist[2]);
    assign w_feed_period = W_CNT'(w_sum >> 2);
    assign w_feed_ok     = (r_hist_n == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist   <= '{default: '0};
            r_hist_n <= '0;
        end else if (w_timeout) begin
            r_hist   <= '{default: '0};
            r_hist_n <= '0;
        end else if (w_period_vld) begin
            r_hist[2] <= r_hist[1];
            r_hist[1] <= r_hist[0];
            r_hist[0] <= w_period;
            if (r_hist_n != 2'd3) begin
                r_hist_n <= r_hist_n + 1'b1;
            end
        end
    end
`else
    assign w_feed_period = w_period;
    assign w_feed_ok     = 1'b1;
`endif

    // Window bounds are constants; only the selected entry is compared each cycle.
    logic [63:0] w_lo [N_ENT];
    logic [63:0] w_hi [N_ENT];
    for (genvar g = 0; g < N_ENT; g++) begin : g_win
        localparam logic [63:0] LO = win_bound(CLK_MHZ, g, TOL_PCT, 1'b0);
        localparam logic [63:0] HI = win_bound(CLK_MHZ, g, TOL_PCT, 1'b1);
        assign w_lo[g] = LO;
        assign w_hi[g] = HI;
    end

    search_state_e    r_state;
    search_state_e    w_state_nxt;
    logic [W_CNT-1:0] r_sp;
    logic [W_K-1:0]   r_k;
    logic [3:0]       r_n;
    logic [W_OCT-1:0] r_o;
    logic             r_res_hit;
    logic [3:0]       r_res_note;
    logic [W_OCT-1:0] r_res_oct;
    logic             w_match;
    logic             w_last;

    assign w_match = (64'(r_sp) > w_lo[r_k]) && (64'(r_sp) < w_hi[r_k]);
    assign w_last  = (r_k == W_K'(N_ENT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_period_vld && w_feed_ok) w_state_nxt = S_SEARCH;
            S_SEARCH: if (w_match || w_last) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp       <= '0;
            r_k        <= '0;
            r_n        <= '0;
            r_o        <= '0;
            r_res_hit  <= 1'b0;
            r_res_note <= '0;
            r_res_oct  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_period_vld && w_feed_ok) begin
                        r_sp <= w_feed_period;
                        r_k  <= '0;
                        r_n  <= '0;
                        r_o  <= '0;
                    end
                end
                S_SEARCH: begin
                    if (w_match) begin
                        r_res_hit  <= 1'b1;
                        r_res_note <= r_n;
                        r_res_oct  <= r_o;
                    end else if (w_last) begin
                        r_res_hit  <= 1'b0;
                        r_res_note <= '0;
                        r_res_oct  <= '0;
                    end else begin
                        r_k <= r_k + 1'b1;
                        if (r_n == 4'd11) begin
                            r_n <= '0;
                            r_o <= r_o + 1'b1;
                        end else begin
                            r_n <= r_n + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    logic             r_cand_hit;
    logic [3:0]       r_cand_note;
    logic [W_OCT-1:0] r_cand_oct;
    logic [W_FC-1:0]  r_fcnt;
    logic [W_FC-1:0]  w_fcnt_nxt;
    logic             w_same;

    assign w_same = (r_res_hit == r_cand_hit) && (r_res_note == r_cand_note)
                 && (r_res_oct == r_cand_oct);

    always_comb begin
        w_fcnt_nxt = W_FC'(1);
        if (w_same) begin
            w_fcnt_nxt = (r_fcnt == W_FC'(STABLE_PERIODS)) ? r_fcnt : r_fcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand_hit  <= 1'b0;
            r_cand_note <= '0;
            r_cand_oct  <= '0;
            r_fcnt      <= '0;
            note_vld    <= 1'b0;
            note_idx    <= '0;
            octave      <= '0;
            note_onehot <= NO_NOTE;
        end else if (w_timeout) begin
            r_cand_hit  <= 1'b0;
            r_cand_note <= '0;
            r_cand_oct  <= '0;
            r_fcnt      <= '0;
            note_vld    <= 1'b0;
            note_idx    <= '0;
            octave      <= '0;
            note_onehot <= NO_NOTE;
        end else if (r_state == S_DONE) begin
            r_cand_hit  <= r_res_hit;
            r_cand_note <= r_res_note;
            r_cand_oct  <= r_res_oct;
            r_fcnt      <= w_fcnt_nxt;
            // Miss results carry zero note/octave, so a stable miss clears the outputs.
            if (w_fcnt_nxt == W_FC'(STABLE_PERIODS)) begin
                note_vld    <= r_res_hit;
                note_idx    <= r_res_note;
                octave      <= r_res_oct;
                note_onehot <= r_res_hit ? note_onehot_f(r_res_note) : NO_NOTE;
            end
        end
    end

endmodule

// File: tb/tb_note_tracker.sv
// Directed bench for note_tracker, built with a 1 MHz table and 12-bit counter to keep runs short.
module tb_note_tracker;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] sample;
    logic               sample_vld;
    logic signed [15:0] thr_hi;
    logic signed [15:0] thr_lo;
    logic [11:0]        period;
    logic               period_vld;
    logic [11:0]        note_onehot;
    logic [3:0]         note_idx;
    logic [1:0]         octave;
    logic               note_vld;

    int n_total = 0;
    int n_bad   = 0;
    int pv_count = 0;
    int pv_base;

    always #5 clk = ~clk;

    note_tracker #(
        .CLK_MHZ(1), .W_SAMPLE(16), .W_CNT(12), .N_OCT(3), .TOL_PCT(3), .STABLE_PERIODS(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample      (sample),
        .sample_vld  (sample_vld),
        .thr_hi      (thr_hi),
        .thr_lo      (thr_lo),
        .period      (period),
        .period_vld  (period_vld),
        .note_onehot (note_onehot),
        .note_idx    (note_idx),
        .octave      (octave),
        .note_vld    (note_vld)
    );

    always @(negedge clk) begin
        if (period_vld === 1'b1) pv_count++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_note(input string tag, input int idx, input int oct,
                              input logic [11:0] oh, input logic vld);
        check_eq({tag, "_idx"}, 32'(note_idx), 32'(idx));
        check_eq({tag, "_oct"}, 32'(octave), 32'(oct));
        check_eq({tag, "_onehot"}, 32'(note_onehot), 32'(oh));
        check_eq({tag, "_vld"}, 32'(note_vld), 32'(vld));
    endtask

    // One square-wave period of p cycles starting with its rising sample; noisy adds
    // +/-0x1000 bursts inside each half that must never cross the opposite threshold.
    task automatic run_period(input int p, input bit noisy);
        int v;
        for (int i = 0; i < p; i++) begin
            @(posedge clk);
            #1;
            v = int'($urandom_range(0, 8192)) - 4096;
            if (i < p / 2) begin
                sample = (noisy && i >= 8 && i < p / 4) ? 16'(v) : 16'sd8000;
            end else begin
                sample = (noisy && i >= p / 2 + 8 && i < 3 * p / 4) ? 16'(v) : -16'sd8000;
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        sample     = '0;
        sample_vld = 1'b0;
        thr_hi     = 16'sh1100;
        thr_lo     = -16'sh1100;
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_period", 32'(period), 0);
        check_eq("rst_period_vld", 32'(period_vld), 0);
        check_note("rst", 0, 0, 12'h000, 1'b0);

        @(negedge clk);
        rst_n      = 1'b1;
        sample     = -16'sd8000;
        sample_vld = 1'b1;
        repeat (4) @(posedge clk);

        // A4 = 2272 cycles at 1 MHz (window 2203..2340, table entry 9)
        pv_base = pv_count;
        repeat (4) run_period(2272, 1'b0);
        check_eq("a4_pv_count", 32'(pv_count - pv_base), 3);
        check_eq("a4_not_yet_vld", 32'(note_vld), 0);
        run_period(2272, 1'b0);
        check_eq("a4_period", 32'(period), 2272);
        check_note("a4", 9, 0, 12'h004, 1'b1);

        // A5 = 1136 cycles; the first call still measures the last A4 period
        repeat (4) run_period(1136, 1'b0);
        check_note("a5_hold", 9, 0, 12'h004, 1'b1);
        run_period(1136, 1'b0);
        check_eq("a5_period", 32'(period), 1136);
        check_note("a5", 9, 1, 12'h004, 1'b1);

        // 400 cycles is shorter than the lowest B6 bound (490): miss
        repeat (4) run_period(400, 1'b0);
        check_note("miss_hold", 9, 1, 12'h004, 1'b1);
        run_period(400, 1'b0);
        check_eq("miss_period", 32'(period), 400);
        check_note("miss", 0, 0, 12'h000, 1'b0);

        // Noisy A4: exactly one rising event per period
        pv_base = pv_count;
        repeat (5) run_period(2272, 1'b1);
        check_eq("noise_pv_count", 32'(pv_count - pv_base), 5);
        check_eq("noise_period", 32'(period), 2272);
        check_note("noise", 9, 0, 12'h004, 1'b1);

        // Last rising edge was 2270 edges ago; counter hits 4095 after 1825 more edges
        repeat (1825) @(posedge clk);
        #1;
        check_eq("pre_sat_vld", 32'(note_vld), 1);
        @(posedge clk);
        #1;
        check_eq("sat_vld", 32'(note_vld), 0);
        check_eq("sat_onehot", 32'(note_onehot), 0);

        pv_base = pv_count;
        run_period(2272, 1'b0);
        check_eq("sat_first_edge_pv", 32'(pv_count - pv_base), 0);
        repeat (4) run_period(2272, 1'b0);
        check_eq("recover_period", 32'(period), 2272);
        check_note("recover", 9, 0, 12'h004, 1'b1);

        // Rising edge, then reset while the search is walking the table
        @(posedge clk);
        #1;
        sample = 16'sd8000;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_period", 32'(period), 0);
        check_eq("midrst_period_vld", 32'(period_vld), 0);
        check_note("midrst", 0, 0, 12'h000, 1'b0);
        repeat (3) @(negedge clk);
        sample = -16'sd8000;
        rst_n  = 1'b1;
        repeat (4) @(posedge clk);

        pv_base = pv_count;
        run_period(2272, 1'b0);
        check_eq("post_rst_first_pv", 32'(pv_count - pv_base), 0);
        run_period(2272, 1'b0);
        check_eq("post_rst_second_pv", 32'(pv_count - pv_base), 1);
        check_eq("post_rst_period", 32'(period), 2272);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
